rca_serial_addsub: RTL and testbench
====================================

Name: rca_serial_addsub

Overview:
- Parametrised, multi-cycle successor to the fixed 8-bit full-adder ripple chain.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, through a DIGIT-bit full-adder ripple slice and a registered inter-digit carry.
- Operands enter and results leave over valid/ready handshakes.
- Serves the image-processing datapath wherever wide adds are needed without a full-width combinational carry chain.

Parameters:
- WIDTH, 16, operand and result width in bits; WIDTH >= 2.
- DIGIT, 4, bits processed per RUN cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails.
- N (localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; borrow-in for subtract.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB.
- overflow  output  1  signed overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, sum = 0, cout = 0, overflow = 0, digit counter = 0, carry register = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. When in_valid is high at a clock edge:
    - capture a, b, sub.
    - effective B = sub ? ~b : b.
    - carry register = sub ? ~cin : cin.
    - counter = 0, go to RUN.
  - RUN: in_ready = 0. Each cycle:
    - add digit [counter*DIGIT +: DIGIT] of A and effective B plus the carry register through the DIGIT-bit ripple slice.
    - write the slice sum into the result register at the same bit position.
    - carry register = slice carry-out.
    - counter increments.
    - When counter = N-1: load cout = slice carry-out, overflow = (carry into MSB) XOR (carry out of MSB), go to DONE.
  - DONE: out_valid = 1. When out_ready is high at a clock edge, go to IDLE.
- Input handshake: in_ready is 0 in DONE, so no new operands are accepted in the same cycle the result is consumed.
- Latency: operands accepted in cycle k; out_valid is first high in cycle k+N+1.
- Throughput: one operation per N+2 cycles when out_ready is held high.
- Subtract semantics: result = A - B - cin mod 2^WIDTH. cout = 1 means no borrow out; cout = 0 means borrow.
- Output holding:
  - sum, cout and overflow change only on the RUN to DONE transition.
  - They are stable while out_valid is high.
  - They hold their last values in IDLE until the next operation completes.
  - Partial digits are written into an internal working register, never directly onto sum.
- Backpressure: out_valid stays high and all outputs stay stable for as long as out_ready is low. There is no timeout.
- Operand changes: a, b, cin and sub are ignored outside the IDLE accept edge; changing them mid-RUN has no effect.
- Reset mid-operation: rst in RUN or DONE returns to IDLE on that edge, discards the operation, and drives all outputs to their reset values.
- Degenerate widths:
  - DIGIT = WIDTH (N = 1): exactly one RUN cycle; out_valid in cycle k+2.
  - DIGIT = 1: bit-serial operation, N = WIDTH.

Test Plan (WIDTH=16, DIGIT=4, N=4 unless stated):
- Add with internal carry propagation: a=0x00FF, b=0x0001, cin=0, sub=0, accepted in cycle k -> out_valid first high in cycle k+5; sum=0x0100, cout=0, overflow=0; in_ready=0 from cycle k+1 until the cycle after the result is consumed.
- Add wrap-around and signed overflow:
  - 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0.
  - 0x7FFF + 0x0001 -> sum=0x8000, cout=0, overflow=1.
  - 0x0000 + 0x0000, cin=1 -> sum=0x0001.
- Subtract:
  - 0x0005 - 0x0007, cin=0 -> sum=0xFFFE, cout=0, overflow=0.
  - 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, overflow=1.
  - 0x0010 - 0x0001, cin=1 -> sum=0x000E, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid rises -> out_valid, sum, cout and overflow are unchanged and in_ready=0 throughout; raise out_ready -> IDLE on the next cycle with in_ready=1; outputs hold.
- Reset mid-RUN: assert rst for 1 cycle in the 2nd RUN cycle -> the next cycle shows in_ready=1, out_valid=0, sum=0; a new operation 0x1234 + 0x1111 completes normally with sum=0x2345.
- Parameter sweep: DIGIT=16 and DIGIT=1, with 1000 random operands each, both modes, random in_valid/out_ready gaps -> every result matches the reference model (A ± B ± cin, cout, overflow); latency is N+1 cycles in every case.

Source files
------------

// File: rtl/rca_serial_addsub.sv
// rca_serial_addsub
//   Multi-cycle add/subtract of two WIDTH-bit operands. Each RUN cycle pushes
//   one DIGIT-bit slice through a full-adder ripple chain. A register carries
//   the carry between slices, so the combinational carry path is only DIGIT
//   bits long.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands valid          in_ready   block accepts operands (IDLE)
//   a, b       WIDTH-bit operands      cin        carry-in (add) / borrow-in (sub)
//   sub        0 = add, 1 = subtract
//   out_valid  result valid (DONE)     out_ready  consumer takes the result
//   sum        WIDTH-bit result        cout       MSB carry-out (sub: 1 = no borrow)
//   overflow   signed overflow
module rca_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Stop elaboration when the operand cannot be split into whole digits.
  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("rca_serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // DIGIT-bit full-adder ripple. The result is packed as
  // {carry into MSB, carry out of MSB, sum bits}.
  function automatic logic [DIGIT+1:0] ripple_slice(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             c
  );
    logic [DIGIT:0]   cy;
    logic [DIGIT-1:0] s;
    cy[0] = c;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]    = x[i] ^ y[i] ^ cy[i];
      cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
    end
    return {cy[DIGIT-1], cy[DIGIT], s};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;       // effective B: already inverted for subtract
  logic [WIDTH-1:0] work_r;    // partial result, copied to sum only when complete
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic [31:0]      base_s;
  logic [DIGIT-1:0] a_dig_s;
  logic [DIGIT-1:0] b_dig_s;
  logic [DIGIT-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic             slice_cmsb_s;
  logic [WIDTH-1:0] next_work_s;
  logic             last_s;

  // Current digit slice, and the working result with that slice merged in.
  always_comb begin
    base_s       = 32'(cnt_r) * 32'(DIGIT);
    a_dig_s      = a_r[base_s +: DIGIT];
    b_dig_s      = b_r[base_s +: DIGIT];
    {slice_cmsb_s, slice_cout_s, slice_sum_s} = ripple_slice(a_dig_s, b_dig_s, carry_r);
    next_work_s  = work_r;
    next_work_s[base_s +: DIGIT] = slice_sum_s;
    last_s       = (cnt_r == CW'(N - 1));
  end

  // Control FSM, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= {WIDTH{1'b0}};
      cout      <= 1'b0;
      overflow  <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      carry_r   <= 1'b0;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      work_r    <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            // Subtract is A + ~B + ~borrow_in.
            b_r      <= sub ? ~b : b;
            carry_r  <= sub ? ~cin : cin;
            cnt_r    <= {CW{1'b0}};
            work_r   <= {WIDTH{1'b0}};
            in_ready <= 1'b0;
            state_r  <= RUN;
          end else begin
            state_r  <= IDLE;
          end
        end
        RUN: begin
          work_r  <= next_work_s;
          carry_r <= slice_cout_s;
          if (last_s) begin
            sum       <= next_work_s;
            cout      <= slice_cout_s;
            overflow  <= slice_cmsb_s ^ slice_cout_s;
            out_valid <= 1'b1;
            cnt_r     <= {CW{1'b0}};
            state_r   <= DONE;
          end else begin
            cnt_r     <= cnt_r + CW'(1);
            state_r   <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r   <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_serial_addsub.sv
// Self-checking bench for rca_serial_addsub.
// Instance 0 uses DIGIT=4 for the directed vectors. Instance 1 uses DIGIT=16
// and instance 2 uses DIGIT=1 for the random parameter sweep.
module tb_rca_serial_addsub;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] sum       [3];
  logic        cout      [3];
  logic        ovf       [3];

  int errors = 0;
  int checks = 0;

  rca_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(sum[0]), .cout(cout[0]), .overflow(ovf[0]));

  rca_serial_addsub #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum(sum[1]), .cout(cout[1]), .overflow(ovf[1]));

  rca_serial_addsub #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .sum(sum[2]), .cout(cout[2]), .overflow(ovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, cout, sum} of A + B + cin, or of A - B - cin.
  function automatic logic [17:0] ref_model(input logic [15:0] av, input logic [15:0] bv,
                                            input logic ci, input logic su);
    logic [15:0] eb;
    logic [16:0] full;
    logic        ov;
    eb   = su ? ~bv : bv;
    full = {1'b0, av} + {1'b0, eb} + {16'd0, (su ? ~ci : ci)};
    ov   = (av[15] == eb[15]) && (full[15] != av[15]);
    return {ov, full[16], full[15:0]};
  endfunction

  // Starts on a negedge with the DUT idle, and ends on a negedge with the DUT idle.
  task automatic do_op(input int s, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic su, input logic [15:0] esum,
                       input logic ecout, input logic eovf, input int lat, input int hold);
    int cyc;
    check_eq("in_ready_idle", in_ready[s], 1'b1);
    a = av; b = bv; cin = ci; sub = su;
    in_valid[s]  = 1'b1;
    out_ready[s] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[s] = 1'b0;
    // Scramble the operands to show they are ignored after the accept edge.
    a = ~av; b = ~bv; cin = ~ci; sub = ~su;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_eq("in_ready_run", in_ready[s], 1'b0);
    end while (!out_valid[s] && cyc < 200);
    check_eq("latency", cyc, lat);
    check_eq("sum", sum[s], esum);
    check_eq("cout", cout[s], ecout);
    check_eq("overflow", ovf[s], eovf);
    check_eq("in_ready_done", in_ready[s], 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("bp_out_valid", out_valid[s], 1'b1);
      check_eq("bp_sum", sum[s], esum);
      check_eq("bp_cout", cout[s], ecout);
      check_eq("bp_overflow", ovf[s], eovf);
      check_eq("bp_in_ready", in_ready[s], 1'b0);
    end
    out_ready[s] = 1'b1;
    @(negedge clk);
    out_ready[s] = 1'b0;
    check_eq("consumed_out_valid", out_valid[s], 1'b0);
    check_eq("consumed_in_ready", in_ready[s], 1'b1);
    check_eq("consumed_sum_hold", sum[s], esum);
    check_eq("consumed_cout_hold", cout[s], ecout);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;
    logic [17:0] exp_v;
    int          gap;

    rst = 1'b1; a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready[0], 1'b1);
    check_eq("rst_out_valid", out_valid[0], 1'b0);
    check_eq("rst_sum", sum[0], 16'h0000);
    check_eq("rst_cout", cout[0], 1'b0);
    check_eq("rst_overflow", ovf[0], 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with DIGIT=4: the result appears N+1 = 5 cycles after acceptance.
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 5, 0);
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5, 0);
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 5, 0);
    do_op(0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 5, 0);
    do_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 5, 0);
    do_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 5, 0);
    do_op(0, 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 5, 0);
    // Backpressure: out_ready stays low for 3 cycles after out_valid rises.
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 5, 3);

    // Reset during the 2nd RUN cycle.
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);      // operands accepted on the edge just passed
    in_valid[0] = 1'b0;
    @(negedge clk);      // 2nd RUN cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_in_ready", in_ready[0], 1'b1);
    check_eq("midrst_out_valid", out_valid[0], 1'b0);
    check_eq("midrst_sum", sum[0], 16'h0000);
    check_eq("midrst_cout", cout[0], 1'b0);
    do_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 5, 0);

    // Random sweep: DIGIT=16 (latency 2), then DIGIT=1 (latency 17).
    for (int s = 1; s < 3; s++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
        exp_v = ref_model(ra, rb, rc, rs);
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
        do_op(s, ra, rb, rc, rs, exp_v[15:0], exp_v[16], exp_v[17],
              (s == 1) ? 2 : 17, $urandom_range(0, 2));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
